// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the set-associative write-back data cache.
//   cache_state_e : controller states (IDLE, WRITE_BACK, ALLOCATE, REFILL)
//   BLOCK_WORDS   : 32-bit words per cache block (fixed by the 128-bit bus)
//   MEM_W/WORD_W  : memory bus and processor word widths
//   way_bits()    : width of a way index (at least one bit, even for WAYS=1)
// -----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2,
        REFILL     = 2'd3
    } cache_state_e;

    localparam int BLOCK_WORDS = 4;
    localparam int MEM_W       = 128;
    localparam int WORD_W      = 32;
    localparam int ADDR_W      = 30;
    localparam int BLK_ADDR_W  = 28;

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_sa_wb_if.sv
// -----------------------------------------------------------------------------
// cache_sa_wb_if
// Bundles the processor-side (MEM stage) and memory-side signals of the cache.
//   proc_read/proc_write/proc_addr/proc_wdata : request from the pipeline
//   proc_rdata/proc_stall                     : load data and pipeline hold
//   mem_read/mem_write/mem_addr/mem_wdata     : block request to memory
//   mem_rdata/mem_ready                       : refill block and completion
// Modports:
//   slave  : the cache itself
//   master : the surrounding environment (pipeline plus block memory)
// -----------------------------------------------------------------------------
interface cache_sa_wb_if;
    import cache_pkg::*;

    logic                  proc_read;
    logic                  proc_write;
    logic [ADDR_W-1:0]     proc_addr;
    logic [WORD_W-1:0]     proc_wdata;
    logic [WORD_W-1:0]     proc_rdata;
    logic                  proc_stall;
    logic                  mem_read;
    logic                  mem_write;
    logic [BLK_ADDR_W-1:0] mem_addr;
    logic [MEM_W-1:0]      mem_wdata;
    logic [MEM_W-1:0]      mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

endinterface

// File: rtl/cache_lru.sv
// -----------------------------------------------------------------------------
// cache_lru
// True-LRU age tracking for every set. Each way holds an age in 0..WAYS-1;
// ages within a set always form a permutation, age 0 = most recently used.
// Ports:
//   clk, proc_reset : clock, asynchronous active-high reset
//   i_upd_en        : record an access to way i_upd_way of set i_set
//   i_set           : set being accessed / queried
//   i_upd_way       : way being accessed
//   o_victim        : way of set i_set whose age is WAYS-1 (least recent)
// -----------------------------------------------------------------------------
module cache_lru
    import cache_pkg::*;
#(
    parameter  int SET_BITS = 2,
    parameter  int WAYS     = 2,
    localparam int WAY_W    = way_bits(WAYS)
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic                i_upd_en,
    input  logic [SET_BITS-1:0] i_set,
    input  logic [WAY_W-1:0]    i_upd_way,
    output logic [WAY_W-1:0]    o_victim
);

    localparam int SETS = 1 << SET_BITS;

    logic [WAY_W-1:0] r_age [SETS][WAYS];
    logic [WAY_W-1:0] w_old_age;
    logic [WAY_W-1:0] w_victim;

    assign w_old_age = r_age[i_set][i_upd_way];

    // Age update: accessed way becomes youngest, younger ways age by one.
    // Reset seeds each set with ages equal to the way index so the set
    // starts out as a valid permutation (all-zero ages would never age).
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= WAY_W'(w);
                end
            end
        end else if (i_upd_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == i_upd_way) begin
                    r_age[i_set][w] <= {WAY_W{1'b0}};
                end else if (r_age[i_set][w] < w_old_age) begin
                    r_age[i_set][w] <= r_age[i_set][w] + WAY_W'(1);
                end
            end
        end
    end

    // Victim lookup: the unique way carrying the oldest age.
    always_comb begin
        w_victim = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            w_victim = (r_age[i_set][w] == WAY_W'(WAYS - 1)) ? WAY_W'(w) : w_victim;
        end
    end

    assign o_victim = w_victim;

endmodule

// File: rtl/cache_sa_wb.sv
// -----------------------------------------------------------------------------
// cache_sa_wb
// Set-associative, write-back, write-allocate data cache between the MEM
// stage and a 128-bit block memory. Blocks are 4 x 32-bit words.
// Ports:
//   clk, proc_reset : clock, asynchronous active-high reset
//   bus             : cache_sa_wb_if.slave (processor and memory signals)
//   hit_cnt/miss_cnt: performance counters, present only when the macro
//                     CACHE_PERF_CNT_EN is defined
// Parameters:
//   SET_BITS : log2(number of sets); index = proc_addr[SET_BITS+1:2]
//   WAYS     : associativity, 1, 2 or 4
// Memory-side outputs are registered; proc_rdata/proc_stall are combinational.
// -----------------------------------------------------------------------------
module cache_sa_wb
    import cache_pkg::*;
#(
    parameter int SET_BITS = 2,
    parameter int WAYS     = 2
) (
    input  logic         clk,
    input  logic         proc_reset,
    cache_sa_wb_if.slave bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int TAG_W = 28 - SET_BITS;
    localparam int SETS  = 1 << SET_BITS;
    localparam int WAY_W = way_bits(WAYS);

    // Cache storage, indexed [way][set]
    logic                  r_valid [WAYS][SETS];
    logic                  r_dirty [WAYS][SETS];
    logic [TAG_W-1:0]      r_tag   [WAYS][SETS];
    logic [MEM_W-1:0]      r_data  [WAYS][SETS];

    cache_state_e          r_state;
    cache_state_e          w_state_nx;

    logic                  r_mem_read,  w_mem_read_nx;
    logic                  r_mem_write, w_mem_write_nx;
    logic [BLK_ADDR_W-1:0] r_mem_addr,  w_mem_addr_nx;
    logic [MEM_W-1:0]      r_mem_wdata, w_mem_wdata_nx;

    logic [BLK_ADDR_W-1:0] r_miss_blk;
    logic [WAY_W-1:0]      r_victim;

    logic [SET_BITS-1:0]   w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_off;
    logic [SET_BITS-1:0]   w_miss_index;
    logic [TAG_W-1:0]      w_miss_tag;

    logic                  w_req;
    logic [WAYS-1:0]       w_way_match;
    logic                  w_hit;
    logic [WAY_W-1:0]      w_hit_way;
    logic [MEM_W-1:0]      w_hit_block;
    logic [WAY_W-1:0]      w_lru_victim;
    logic [WAY_W-1:0]      w_victim;

    logic                  w_miss_det;
    logic                  w_fill;
    logic                  w_wr_hit;
    logic                  w_lru_upd;

    assign w_index      = bus.proc_addr[SET_BITS+1:2];
    assign w_tag        = bus.proc_addr[29:SET_BITS+2];
    assign w_off        = bus.proc_addr[1:0];
    assign w_miss_index = r_miss_blk[SET_BITS-1:0];
    assign w_miss_tag   = r_miss_blk[BLK_ADDR_W-1:SET_BITS];
    assign w_req        = bus.proc_read | bus.proc_write;

    // Tag compare across all ways of the addressed set.
    always_comb begin
        w_way_match = {WAYS{1'b0}};
        w_hit_way   = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            w_way_match[w] = r_valid[w][w_index] && (r_tag[w][w_index] == w_tag);
            w_hit_way      = w_way_match[w] ? WAY_W'(w) : w_hit_way;
        end
    end

    assign w_hit       = |w_way_match;
    assign w_hit_block = r_data[w_hit_way][w_index];

    // Victim: lowest-index invalid way wins over the LRU choice.
    always_comb begin
        w_victim = w_lru_victim;
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_victim = r_valid[w][w_index] ? w_victim : WAY_W'(w);
        end
    end

    generate
        if (WAYS > 1) begin : g_lru
            cache_lru #(
                .SET_BITS (SET_BITS),
                .WAYS     (WAYS)
            ) u_lru (
                .clk        (clk),
                .proc_reset (proc_reset),
                .i_upd_en   (w_lru_upd),
                .i_set      (w_index),
                .i_upd_way  (w_hit_way),
                .o_victim   (w_lru_victim)
            );
        end else begin : g_no_lru
            assign w_lru_victim = {WAY_W{1'b0}};
        end
    endgenerate

    // Next-state and next memory-side register values.
    always_comb begin
        w_state_nx     = r_state;
        w_mem_read_nx  = r_mem_read;
        w_mem_write_nx = r_mem_write;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_miss_det     = 1'b0;
        w_fill         = 1'b0;
        w_wr_hit       = 1'b0;
        w_lru_upd      = 1'b0;
        case (r_state)
            IDLE: begin
                w_mem_read_nx  = 1'b0;
                w_mem_write_nx = 1'b0;
                w_mem_addr_nx  = {BLK_ADDR_W{1'b0}};
                w_mem_wdata_nx = {MEM_W{1'b0}};
                if (w_req && w_hit) begin
                    w_lru_upd = 1'b1;
                    w_wr_hit  = bus.proc_write;
                end else if (w_req) begin
                    w_miss_det = 1'b1;
                    // Only valid ways can be dirty, so dirty alone decides.
                    if (r_dirty[w_victim][w_index]) begin
                        w_state_nx     = WRITE_BACK;
                        w_mem_write_nx = 1'b1;
                        w_mem_addr_nx  = {r_tag[w_victim][w_index], w_index};
                        w_mem_wdata_nx = r_data[w_victim][w_index];
                    end else begin
                        w_state_nx    = ALLOCATE;
                        w_mem_read_nx = 1'b1;
                        w_mem_addr_nx = bus.proc_addr[29:2];
                    end
                end else begin
                    w_state_nx = IDLE;
                end
            end
            WRITE_BACK: begin
                if (bus.mem_ready) begin
                    w_state_nx     = ALLOCATE;
                    w_mem_write_nx = 1'b0;
                    w_mem_read_nx  = 1'b1;
                    w_mem_addr_nx  = r_miss_blk;
                    w_mem_wdata_nx = {MEM_W{1'b0}};
                end else begin
                    w_state_nx = WRITE_BACK;
                end
            end
            ALLOCATE: begin
                if (bus.mem_ready) begin
                    w_state_nx    = REFILL;
                    w_fill        = 1'b1;
                    w_mem_read_nx = 1'b0;
                    w_mem_addr_nx = {BLK_ADDR_W{1'b0}};
                end else begin
                    w_state_nx = ALLOCATE;
                end
            end
            REFILL: begin
                w_state_nx     = IDLE;
                w_mem_read_nx  = 1'b0;
                w_mem_write_nx = 1'b0;
                w_mem_addr_nx  = {BLK_ADDR_W{1'b0}};
                w_mem_wdata_nx = {MEM_W{1'b0}};
            end
            default: begin
                w_state_nx     = IDLE;
                w_mem_read_nx  = 1'b0;
                w_mem_write_nx = 1'b0;
                w_mem_addr_nx  = {BLK_ADDR_W{1'b0}};
                w_mem_wdata_nx = {MEM_W{1'b0}};
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Registered memory-side outputs; the async reset drops requests at once.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {BLK_ADDR_W{1'b0}};
            r_mem_wdata <= {MEM_W{1'b0}};
        end else begin
            r_mem_read  <= w_mem_read_nx;
            r_mem_write <= w_mem_write_nx;
            r_mem_addr  <= w_mem_addr_nx;
            r_mem_wdata <= w_mem_wdata_nx;
        end
    end

    // Miss context: the fill works from these, not from proc_addr.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_miss_blk <= {BLK_ADDR_W{1'b0}};
            r_victim   <= {WAY_W{1'b0}};
        end else if (w_miss_det) begin
            r_miss_blk <= bus.proc_addr[29:2];
            r_victim   <= w_victim;
        end
    end

    // Storage update: block refill or single-word write merge.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_tag[w][s]   <= {TAG_W{1'b0}};
                    r_data[w][s]  <= {MEM_W{1'b0}};
                end
            end
        end else if (w_fill) begin
            r_data[r_victim][w_miss_index]  <= bus.mem_rdata;
            r_valid[r_victim][w_miss_index] <= 1'b1;
            r_dirty[r_victim][w_miss_index] <= 1'b0;
            r_tag[r_victim][w_miss_index]   <= w_miss_tag;
        end else if (w_wr_hit) begin
            r_data[w_hit_way][w_index][{w_off, 5'd0} +: WORD_W] <= bus.proc_wdata;
            r_dirty[w_hit_way][w_index] <= 1'b1;
        end
    end

    assign bus.proc_rdata = w_hit ? w_hit_block[{w_off, 5'd0} +: WORD_W] : {WORD_W{1'b0}};
    assign bus.proc_stall = w_req & ((r_state != IDLE) | ~w_hit);
    assign bus.mem_read   = r_mem_read;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;

`ifdef CACHE_PERF_CNT_EN
    logic        r_after_refill;
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        w_hit_access;

    assign w_hit_access = (r_state == IDLE) & w_req & w_hit;

    // Hit/miss counters; the re-hit right after a refill belongs to the miss.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            r_after_refill <= 1'b0;
            r_hit_cnt      <= 32'd0;
            r_miss_cnt     <= 32'd0;
        end else begin
            r_after_refill <= (r_state == REFILL);
            if (w_hit_access && !r_after_refill) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss_det) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_sa_wb.sv
// -----------------------------------------------------------------------------
// tb_cache_sa_wb
// Directed bench for cache_sa_wb (SET_BITS=2, WAYS=2). A transaction-level
// model (resident blocks per set kept in recency order, plus a backing store)
// derives the expected cycle timeline of every access; one negedge process
// compares the DUT against it, and literal values pin the model.
// -----------------------------------------------------------------------------
module tb_cache_sa_wb;
    import cache_pkg::*;

    localparam int MWAYS = 2;
    localparam int MSETS = 4;

    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    cache_sa_wb_if bus();

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    cache_sa_wb #(
        .SET_BITS (2),
        .WAYS     (2)
    ) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    logic         chk_en = 1'b0;
    logic         exp_stall, exp_mrd, exp_mwr, exp_rchk;
    logic [27:0]  exp_addr;
    logic [127:0] exp_wdata;
    logic [31:0]  exp_rdata;

    logic [27:0]  seen_wb_addr, seen_alloc_addr;
    logic [127:0] seen_wb_data;
    logic [31:0]  seen_rdata;

    // Model: resident blocks per set, most recent first
    logic [27:0]  lru_q [MSETS][$];
    logic [127:0] mdata [logic [27:0]];
    bit           mdirty [logic [27:0]];
    logic [127:0] backing [logic [27:0]];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pattern(input logic [27:0] b);
        logic [127:0] v;
        for (int k = 0; k < 4; k++) begin
            v[32*k +: 32] = 32'h1000_0000 + (32'(b) << 4) + 32'(k);
        end
        return v;
    endfunction

    function automatic logic [127:0] backing_get(input logic [27:0] b);
        if (backing.exists(b)) return backing[b];
        return pattern(b);
    endfunction

    function automatic int find_q(input int s, input logic [27:0] b);
        for (int i = 0; i < lru_q[s].size(); i++) begin
            if (lru_q[s][i] == b) return i;
        end
        return -1;
    endfunction

    // Per-cycle comparator
    always @(negedge clk) begin
        if (chk_en) begin
            check("proc_stall", {127'd0, bus.proc_stall}, {127'd0, exp_stall});
            check("mem_read",   {127'd0, bus.mem_read},   {127'd0, exp_mrd});
            check("mem_write",  {127'd0, bus.mem_write},  {127'd0, exp_mwr});
            if (exp_mrd || exp_mwr) check("mem_addr", {100'd0, bus.mem_addr}, {100'd0, exp_addr});
            if (exp_mwr) begin
                check("mem_wdata", bus.mem_wdata, exp_wdata);
                seen_wb_addr = bus.mem_addr;
                seen_wb_data = bus.mem_wdata;
            end
            if (exp_mrd) seen_alloc_addr = bus.mem_addr;
            if (exp_rchk) begin
                check("proc_rdata", {96'd0, bus.proc_rdata}, {96'd0, exp_rdata});
                seen_rdata = bus.proc_rdata;
            end
        end
    end

    task automatic set_exp(input logic st, input logic mrd, input logic mwr, input logic [27:0] a,
                           input logic [127:0] wd, input logic rchk, input logic [31:0] rd);
        exp_stall = st; exp_mrd = mrd; exp_mwr = mwr; exp_addr = a;
        exp_wdata = wd; exp_rchk = rchk; exp_rdata = rd;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
    endtask

    // One processor access, memory answering after 'lat' cycles per phase
    task automatic access(input logic [29:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input int lat);
        logic [27:0]  blk = a[29:2];
        int           s   = int'(a[3:2]);
        logic [1:0]   off = a[1:0];
        logic [27:0]  vic;
        logic [127:0] tmp;
        bus.proc_addr  = a;
        bus.proc_read  = rd;
        bus.proc_write = wr;
        bus.proc_wdata = wd;
        chk_en = 1'b1;
        if (find_q(s, blk) < 0) begin
            set_exp(1'b1, 1'b0, 1'b0, 28'd0, 128'd0, 1'b0, 32'd0);
            tick();
            if (lru_q[s].size() == MWAYS) begin
                vic = lru_q[s][$];
                void'(lru_q[s].pop_back());
                if (mdirty[vic]) begin
                    for (int i = 0; i < lat; i++) begin
                        set_exp(1'b1, 1'b0, 1'b1, vic, mdata[vic], 1'b0, 32'd0);
                        bus.mem_ready = (i == lat - 1);
                        tick();
                    end
                    backing[vic] = mdata[vic];
                end
                mdata.delete(vic);
                mdirty.delete(vic);
            end
            for (int i = 0; i < lat; i++) begin
                set_exp(1'b1, 1'b1, 1'b0, blk, 128'd0, 1'b0, 32'd0);
                bus.mem_rdata = backing_get(blk);
                bus.mem_ready = (i == lat - 1);
                tick();
            end
            mdata[blk]  = backing_get(blk);
            mdirty[blk] = 1'b0;
            lru_q[s].push_front(blk);
            set_exp(1'b1, 1'b0, 1'b0, 28'd0, 128'd0, 1'b0, 32'd0);
            tick();
        end
        lru_q[s].delete(find_q(s, blk));
        lru_q[s].push_front(blk);
        tmp = mdata[blk];
        set_exp(1'b0, 1'b0, 1'b0, 28'd0, 128'd0, 1'b1, tmp[{off, 5'd0} +: 32]);
        tick();
        if (wr) begin
            tmp[{off, 5'd0} +: 32] = wd;
            mdata[blk]  = tmp;
            mdirty[blk] = 1'b1;
        end
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
    endtask

    // Read miss aborted by reset in its first ALLOCATE cycle (clean victim)
    task automatic abort_during_alloc(input logic [29:0] a);
        bus.proc_addr = a;
        bus.proc_read = 1'b1;
        chk_en = 1'b1;
        set_exp(1'b1, 1'b0, 1'b0, 28'd0, 128'd0, 1'b0, 32'd0);
        tick();
        set_exp(1'b1, 1'b1, 1'b0, a[29:2], 128'd0, 1'b0, 32'd0);
        @(negedge clk);
        #1;
        proc_reset = 1'b1;
        chk_en = 1'b0;
        #1;
        check("abort_mem_read", {127'd0, bus.mem_read}, 128'd0);
        bus.proc_read = 1'b0;
        @(posedge clk);
        #1;
        proc_reset = 1'b0;
        for (int s = 0; s < MSETS; s++) lru_q[s].delete();
        mdata.delete();
        mdirty.delete();
        chk_en = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 28'd0, 128'd0, 1'b0, 32'd0);
        tick();
    endtask

    initial begin
        proc_reset     = 1'b1;
        bus.proc_read  = 1'b0;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'd0;
        bus.proc_wdata = 32'd0;
        bus.mem_rdata  = 128'd0;
        bus.mem_ready  = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 28'd0, 128'd0, 1'b0, 32'd0);
        tick();
        proc_reset = 1'b0;
        tick();

        access(30'h10, 1'b1, 1'b0, 32'd0, 2);
        check("first_alloc_addr", {100'd0, seen_alloc_addr}, {100'd0, 28'h0000004});
        check("first_rdata_A", {96'd0, seen_rdata}, {96'd0, 32'h1000_0040});
        access(30'h12, 1'b1, 1'b0, 32'd0, 1);
        check("hit_word2_C", {96'd0, seen_rdata}, {96'd0, 32'h1000_0042});
        access(30'h20, 1'b1, 1'b0, 32'd0, 1);
        access(30'h11, 1'b0, 1'b1, 32'h1111_1111, 1);
        access(30'h30, 1'b1, 1'b0, 32'd0, 3);
        access(30'h10, 1'b1, 1'b0, 32'd0, 1);
        access(30'h10, 1'b0, 1'b1, 32'hDEAD_BEEF, 1);
        access(30'h40, 1'b1, 1'b0, 32'd0, 2);
        access(30'h50, 1'b1, 1'b0, 32'd0, 2);
        check("wb_addr", {100'd0, seen_wb_addr}, {100'd0, 28'h0000004});
        check("wb_word0", {96'd0, seen_wb_data[31:0]}, {96'd0, 32'hDEAD_BEEF});
        check("wb_word1", {96'd0, seen_wb_data[63:32]}, {96'd0, 32'h1111_1111});
        access(30'h10, 1'b1, 1'b0, 32'd0, 1);
        check("refetch_written_back", {96'd0, seen_rdata}, {96'd0, 32'hDEAD_BEEF});
        access(30'h14, 1'b1, 1'b1, 32'hCAFE_F00D, 2);
        check("rw_shows_prewrite", {96'd0, seen_rdata}, {96'd0, 32'h1000_0050});
        access(30'h14, 1'b1, 1'b0, 32'd0, 1);
        check("rw_merged", {96'd0, seen_rdata}, {96'd0, 32'hCAFE_F00D});
        access(30'h2C, 1'b1, 1'b0, 32'd0, 3);
        access(30'h1A, 1'b0, 1'b1, 32'h5555_AAAA, 1);
        access(30'h1A, 1'b1, 1'b0, 32'd0, 1);
        check("write_alloc", {96'd0, seen_rdata}, {96'd0, 32'h5555_AAAA});

        abort_during_alloc(30'h64);

        access(30'h10, 1'b1, 1'b0, 32'd0, 1);
        access(30'h10, 1'b1, 1'b0, 32'd0, 1);
        access(30'h11, 1'b1, 1'b0, 32'd0, 1);
        access(30'h20, 1'b1, 1'b0, 32'd0, 1);
        access(30'h20, 1'b1, 1'b0, 32'd0, 1);
`ifdef CACHE_PERF_CNT_EN
        check("hit_cnt", {96'd0, hit_cnt}, {96'd0, 32'd3});
        check("miss_cnt", {96'd0, miss_cnt}, {96'd0, 32'd2});
`endif
        access(30'h14, 1'b1, 1'b0, 32'd0, 2);
        check("post_reset_refetch", {96'd0, seen_rdata}, {96'd0, 32'h1000_0050});

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_sa_wb.md
Name: cache_sa_wb

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between pipeline MEM stage and 128-bit block memory.
- Generalises the direct-mapped controller: configurable set count and associativity, true-LRU replacement, registered memory-side outputs, request-qualified stall.
- Block = 4 x 32-bit words, fixed by the 128-bit memory bus.

Parameters:
- SET_BITS, 2, log2(number of sets); index = proc_addr[SET_BITS+1:2].
- WAYS, 2, associativity; legal values 1, 2, 4.
- TAG_W, 28-SET_BITS, derived; tag = proc_addr[29:SET_BITS+2].

Ports:
- clk  in  1  clock, rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  load request.
- proc_write  in  1  store request.
- proc_addr  in  30  word address; [1:0] word offset.
- proc_wdata  in  32  store data.
- proc_rdata  out  32  load data, combinational on hit.
- proc_stall  out  1  hold pipeline.
- mem_read  out  1  block read request, registered.
- mem_write  out  1  block write request, registered.
- mem_addr  out  28  block address, registered.
- mem_wdata  out  128  write-back block, registered; word0 in [31:0].
- mem_rdata  in  128  refill block.
- mem_ready  in  1  one-cycle completion strobe from memory.

Behaviour:
- Reset value on proc_reset: all valid, dirty, tag, LRU and data cleared; state = IDLE; mem_read = 0, mem_write = 0, mem_addr = 0, mem_wdata = 0.
- Reset asserted mid-transfer aborts immediately. Memory-side requests drop asynchronously. Lost dirty data is acceptable.
- Request: req = proc_read | proc_write. Both high is treated as a write; proc_rdata shows the pre-write word.
- Hit: some way w has valid && tag match; at most one way matches.
- proc_stall = req & ~hit in IDLE; 1 in every other state; 0 when there is no request.
- IDLE, hit:
  - Zero-cycle read.
  - Write updates the word and sets dirty[w] at the next edge.
  - LRU update at the next edge: way w age becomes 0; ways with age below w's old age increment.
- IDLE, miss with req:
  - Latch the address into miss_addr_r.
  - Pick the victim: lowest-index invalid way; otherwise the way with age WAYS-1.
  - Victim dirty: go to WRITE_BACK with mem_write = 1, mem_addr = {victim tag, index}, mem_wdata = victim block.
  - Victim clean: go to ALLOCATE with mem_read = 1, mem_addr = miss_addr_r[29:2].
- WRITE_BACK: hold outputs until mem_ready. On mem_ready: mem_write = 0, mem_read = 1, mem_addr = miss block, go to ALLOCATE.
- ALLOCATE: hold until mem_ready. On mem_ready: capture mem_rdata into the victim way, set valid = 1, dirty = 0, tag = miss tag, mem_read = 0, go to REFILL.
- REFILL: one bubble cycle, then IDLE. The re-compare hits; a pending write then merges and sets dirty.
- Miss latency:
  - Clean miss: 1 (IDLE) + ALLOCATE cycles up to and including mem_ready + 1 (REFILL); the hit completes in the following IDLE cycle.
  - Dirty miss: adds the WRITE_BACK cycles.
- Processor must hold proc_addr, proc_read, proc_write and proc_wdata stable while stalled. The cache uses miss_addr_r, not proc_addr, during the fill.
- mem_read and mem_write are never both 1. In IDLE and REFILL, memory outputs return to 0.
- WAYS = 1: no LRU storage; victim is always way 0.

Optional Feature:
- CACHE_PERF_CNT_EN defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset 0.
  - hit_cnt increments on each IDLE cycle with req & hit, excluding the REFILL-following re-hit of a miss.
  - miss_cnt increments on each IDLE miss detection.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent.

Decomposition:
- Package cache_pkg: state enum (IDLE, WRITE_BACK, ALLOCATE, REFILL), BLOCK_WORDS = 4, MEM_W = 128, WORD_W = 32.
- Sub-module cache_lru: per-set age array with an access/update port and a victim output, parametrised by SET_BITS and WAYS.

Test Plan:
- Reset, then read 0x00000010 -> stall asserted; ALLOCATE with mem_read = 1, mem_addr = 0x0000004; mem_ready with rdata {D,C,B,A} -> REFILL, then rdata = A, stall = 0.
- Read the same block again at word 2 -> no stall, proc_rdata = C in the same cycle, no memory activity.
- WAYS = 2, SET_BITS = 2: fill set 0 with tags 1 and 2, write tag 1, read tag 3 -> tag 2 (LRU, clean) is evicted with no WRITE_BACK; a following tag 1 read hits.
- Write 0xDEADBEEF to tag 1 set 0 word 0, then miss twice to evict it -> mem_write = 1, mem_addr = {tag1, set0}, mem_wdata[31:0] = 0xDEADBEEF; then ALLOCATE.
- Assert proc_reset during ALLOCATE -> mem_read drops within the same cycle; a subsequent read of the previously cached block misses.
- CACHE_PERF_CNT_EN: 3 hits + 2 misses -> hit_cnt = 3, miss_cnt = 2.
